board_renderer: RTL and testbench
=================================

// Module: board_renderer
// PURPOSE
// - Reader side of the board_state store: walks the 10x20 visible playfield once per start pulse and emits
//   one pixel write per cycle to the VGA adapter, overlaying the live tetromino on the settled blocks.
// - Sits between the game datapath (board_state rows + four current block coordinates) and the VGA adapter.
// - Reads the board through a one-row-at-a-time port, so the game side keeps sole ownership of the array.
// PARAMETERS
// - CELL_PX        5     pixel edge of one cell (1..8)
// - X0             55    screen x of the board's left edge
// - Y0             10    screen y of the board's top edge
// - EMPTY_COLOUR   3'b000  colour of an empty cell
// - FILLED_COLOUR  3'b111  colour of a settled block
// - ACTIVE_COLOUR  3'b100  colour of a cell in the falling tetromino
// - GRID_EN        1     1: draw the last pixel row/column of every cell in GRID_COLOUR
// - GRID_COLOUR    3'b001  grid line colour
// PORTS
// - clock_framerate  in   1   game clock; all state changes on its rising edge
// - resetn           in   1   synchronous, active-low reset
// - start            in   1   one-cycle pulse: render one full frame
// - busy             out  1   high from the cycle after an accepted start until done
// - done             out  1   one-cycle pulse after the final pixel
// - row_addr         out  5   board row requested (0 = bottom row)
// - row_data         in   10  board_state[row_addr]; valid one cycle after row_addr changes; bit n = column n
// - blkN_x (N=1..4)  in   4   column of tetromino block N
// - blkN_y (N=1..4)  in   5   row of tetromino block N
// - vga_x            out  8   pixel x
// - vga_y            out  7   pixel y
// - vga_colour       out  3   pixel colour
// - vga_plot         out  1   write strobe; vga_x/y/colour are valid when high
// BEHAVIOUR
// - Reset: state IDLE; busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, row_addr=19.
//   Reset asserted mid-frame aborts the frame immediately. No done pulse follows, and no pixel is written
//   in the reset cycle.
// - FSM states: IDLE -> REQ -> WAIT -> DRAW -> (REQ | FIN) -> IDLE.
//   - IDLE: start=1 latches blk1..4_x/y into snapshot registers, sets row=19, and goes to REQ.
//     Later changes to blkN_* have no effect on the frame in progress.
//   - REQ: drives row_addr=row, then goes to WAIT.
//   - WAIT: captures row_data into row_buf, clears col/px/py, then goes to DRAW.
//   - DRAW: vga_plot=1 every cycle. Scan order is px fastest, then py, then col.
//     - After px=CELL_PX-1, py=CELL_PX-1, col=9: if row==0 go to FIN, else row<=row-1 and go to REQ.
//   - FIN: done=1 for one cycle, busy=0, then IDLE.
// - start while busy is ignored; it is not queued.
// - Pixel address:
//   - vga_x = X0 + col*CELL_PX + px
//   - vga_y = Y0 + (19-row)*CELL_PX + py
//   - Row 19 is drawn at the top of the screen.
//   - Sums are computed at 8 bits, and vga_y is truncated to 7 bits. The parameters must keep the board
//     within 160x120; this is not checked in hardware.
// - Colour priority, highest first:
//   1. GRID_EN && (px==CELL_PX-1 || py==CELL_PX-1) -> GRID_COLOUR
//   2. (col,row) equals any snapshot block -> ACTIVE_COLOUR
//   3. row_buf[col] -> FILLED_COLOUR
//   4. otherwise EMPTY_COLOUR
// - Snapshot blocks with y>=20 (hidden spawn rows) or x>=10 never match a cell, so they are not drawn.
// - vga_x/y/colour are registered and hold their last value while vga_plot=0.
// - Latency from start to the first plot is 3 cycles.
// - Frame length is exactly 1 + 20*(2 + 10*CELL_PX^2) + 1 cycles; 5042 cycles at CELL_PX=5.
// STRUCTURE
// - tetris_pkg holds BOARD_W=10, BOARD_VIS_H=20, the colour codes, and the FSM state encoding.
// - Sub-module cell_scan_counter: px/py/col nested counter with wrap and last-pixel flags, parameterised
//   by CELL_PX and BOARD_W.
// - Colour select and address arithmetic stay in board_renderer.
// TESTING
// - Empty board with all blocks at y=22, start pulse:
//   - exactly 5000 plots, all EMPTY_COLOUR or GRID_COLOUR;
//   - first plot at (55,10), last plot at (104,109);
//   - done asserts on cycle 5041 after start.
// - board_state[0]=10'b1, GRID_EN=0: only the 25 pixels x 55..59, y 105..109 are FILLED_COLOUR.
// - All four blocks at (4,19) over a filled row 19: the 25 pixels x 75..79, y 10..14 are ACTIVE_COLOUR,
//   so active overrides filled.
// - Change blk1_x every cycle mid-frame: output is identical to a frame rendered with the values latched
//   at start.
// - Pulse start again at cycle 100 of a frame: no restart, still exactly one done.
// - Assert resetn=0 at cycle 2000: next cycle busy=0 and vga_plot=0, with no done pulse. A start after
//   release renders a full correct frame.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, colour codes and renderer state encoding
package tetris_pkg;

    localparam int BOARD_W     = 10;
    localparam int BOARD_VIS_H = 20;

    localparam logic [2:0] COLOUR_EMPTY  = 3'b000;
    localparam logic [2:0] COLOUR_FILLED = 3'b111;
    localparam logic [2:0] COLOUR_ACTIVE = 3'b100;
    localparam logic [2:0] COLOUR_GRID   = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DRAW = 3'd3,
        ST_FIN  = 3'd4
    } render_state_e;

endpackage

// File: rtl/cell_scan_counter.sv
// rtl/cell_scan_counter.sv - px/py/col nested scan counter with wrap and last-pixel flag
module cell_scan_counter #(
    parameter int CELL_PX = 5,
    parameter int BOARD_W = 10
) (
    input  logic       clock_framerate,
    input  logic       resetn,
    input  logic       clear,
    input  logic       advance,
    output logic [2:0] px_next,
    output logic [2:0] py_next,
    output logic [3:0] col_next,
    output logic       last
);

    localparam logic [2:0] PX_MAX  = 3'(CELL_PX - 1);
    localparam logic [3:0] COL_MAX = 4'(BOARD_W - 1);

    logic [2:0] px_q, px_d;
    logic [2:0] py_q, py_d;
    logic [3:0] col_q, col_d;
    logic       px_last, py_last, col_last;

    // Successor of the current position: px fastest, then py, then col, all wrapping.
    always_comb begin
        px_last  = (px_q == PX_MAX);
        py_last  = (py_q == PX_MAX);
        col_last = (col_q == COL_MAX);
        last     = px_last && py_last && col_last;
        px_next  = px_last ? 3'd0 : px_q + 3'd1;
        py_next  = py_q;
        col_next = col_q;
        if (px_last) begin
            py_next = py_last ? 3'd0 : py_q + 3'd1;
            if (py_last) begin
                col_next = col_last ? 4'd0 : col_q + 4'd1;
            end
        end
        px_d  = px_q;
        py_d  = py_q;
        col_d = col_q;
        if (clear) begin
            px_d  = 3'd0;
            py_d  = 3'd0;
            col_d = 4'd0;
        end else if (advance) begin
            px_d  = px_next;
            py_d  = py_next;
            col_d = col_next;
        end
    end

    // Position registers.
    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            px_q  <= 3'd0;
            py_q  <= 3'd0;
            col_q <= 4'd0;
        end else begin
            px_q  <= px_d;
            py_q  <= py_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - walks the visible playfield and streams one pixel write per cycle
module board_renderer
    import tetris_pkg::*;
#(
    parameter int         CELL_PX       = 5,
    parameter int         X0            = 55,
    parameter int         Y0            = 10,
    parameter logic [2:0] EMPTY_COLOUR  = COLOUR_EMPTY,
    parameter logic [2:0] FILLED_COLOUR = COLOUR_FILLED,
    parameter logic [2:0] ACTIVE_COLOUR = COLOUR_ACTIVE,
    parameter bit         GRID_EN       = 1'b1,
    parameter logic [2:0] GRID_COLOUR   = COLOUR_GRID
) (
    input  logic       clock_framerate,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] row_addr,
    input  logic [9:0] row_data,
    input  logic [3:0] blk1_x,
    input  logic [4:0] blk1_y,
    input  logic [3:0] blk2_x,
    input  logic [4:0] blk2_y,
    input  logic [3:0] blk3_x,
    input  logic [4:0] blk3_y,
    input  logic [3:0] blk4_x,
    input  logic [4:0] blk4_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [2:0] PX_MAX  = 3'(CELL_PX - 1);
    localparam logic [4:0] TOP_ROW = 5'(BOARD_VIS_H - 1);

    render_state_e   state_q, state_d;
    logic [4:0]      row_q, row_d;
    logic [9:0]      row_buf_q, row_buf_d;
    logic [3:0][3:0] snap_x_q, snap_x_d;
    logic [3:0][4:0] snap_y_q, snap_y_d;
    logic [7:0]      vga_x_q, vga_x_d;
    logic [6:0]      vga_y_q, vga_y_d;
    logic [2:0]      vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;

    logic       cnt_clear, cnt_advance, cnt_last;
    logic [2:0] px_next, py_next;
    logic [3:0] col_next;

    logic [2:0] sel_px, sel_py;
    logic [3:0] sel_col;
    logic [9:0] sel_bits;
    logic       blk_hit;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       load;

    cell_scan_counter #(
        .CELL_PX (CELL_PX),
        .BOARD_W (BOARD_W)
    ) u_scan (
        .clock_framerate (clock_framerate),
        .resetn          (resetn),
        .clear           (cnt_clear),
        .advance         (cnt_advance),
        .px_next         (px_next),
        .py_next         (py_next),
        .col_next        (col_next),
        .last            (cnt_last)
    );

    // Outputs are registered, so the pixel shown next cycle is selected now:
    // the first cell of a row comes straight off row_data while it is being captured.
    always_comb begin
        sel_px   = 3'd0;
        sel_py   = 3'd0;
        sel_col  = 4'd0;
        sel_bits = row_data;
        if (state_q == ST_DRAW) begin
            sel_px   = px_next;
            sel_py   = py_next;
            sel_col  = col_next;
            sel_bits = row_buf_q;
        end
    end

    // Screen address and colour priority for the selected pixel.
    always_comb begin
        blk_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (snap_x_q[i] == sel_col && snap_y_q[i] == row_q) begin
                blk_hit = 1'b1;
            end
        end
        pix_x = 8'(X0) + 8'(sel_col) * 8'(CELL_PX) + 8'(sel_px);
        pix_y = 7'(Y0) + 7'(TOP_ROW - row_q) * 7'(CELL_PX) + 7'(sel_py);
        if (GRID_EN && (sel_px == PX_MAX || sel_py == PX_MAX)) begin
            pix_colour = GRID_COLOUR;
        end else if (blk_hit) begin
            pix_colour = ACTIVE_COLOUR;
        end else if (sel_bits[sel_col]) begin
            pix_colour = FILLED_COLOUR;
        end else begin
            pix_colour = EMPTY_COLOUR;
        end
    end

    // Frame sequencing: one row request, one capture cycle, then a full row of pixels.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        row_buf_d    = row_buf_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_x_d = {blk4_x, blk3_x, blk2_x, blk1_x};
                    snap_y_d = {blk4_y, blk3_y, blk2_y, blk1_y};
                    row_d    = TOP_ROW;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                row_buf_d = row_data;
                cnt_clear = 1'b1;
                load      = 1'b1;
                state_d   = ST_DRAW;
            end
            ST_DRAW: begin
                cnt_advance = 1'b1;
                if (cnt_last) begin
                    if (row_q == 5'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        row_d   = row_q - 5'd1;
                        state_d = ST_REQ;
                    end
                end else begin
                    load = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        vga_plot_d   = load;
        vga_x_d      = load ? pix_x : vga_x_q;
        vga_y_d      = load ? pix_y : vga_y_q;
        vga_colour_d = load ? pix_colour : vga_colour_q;
    end

    // State, row buffer, snapshot and output registers.
    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            row_q        <= TOP_ROW;
            row_buf_q    <= 10'd0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            row_buf_q    <= row_buf_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign busy       = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAW);
    assign done       = (state_q == ST_FIN);
    assign row_addr   = row_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - randomized frame checks of board_renderer against a per-pixel model
module tb_board_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, start;
    logic [3:0] bx[4];
    logic [4:0] by[4];
    logic [9:0] board[20];

    logic       busy0, done0, vp0, busy1, done1, vp1;
    logic [4:0] ra0, ra1;
    logic [9:0] rd0, rd1;
    logic [7:0] vx0, vx1;
    logic [6:0] vy0, vy1;
    logic [2:0] vc0, vc1;

    int tests = 0;
    int fails = 0;

    int exp_pix[2][5000];
    int r_nplot[2], r_bad[2], r_ndone[2], r_done_cyc[2], r_cnt_fill[2], r_cnt_act[2];
    int r_bad_idx[2], r_bad_got[2], r_bad_exp[2];
    int r_first_cyc, r_first, r_last, r_busy_bad;
    logic [5:0] r_rst_obs;

    board_renderer #(.GRID_EN(1'b1)) dut0 (
        .clock_framerate (clk), .resetn (resetn), .start (start),
        .busy (busy0), .done (done0), .row_addr (ra0), .row_data (rd0),
        .blk1_x (bx[0]), .blk1_y (by[0]), .blk2_x (bx[1]), .blk2_y (by[1]),
        .blk3_x (bx[2]), .blk3_y (by[2]), .blk4_x (bx[3]), .blk4_y (by[3]),
        .vga_x (vx0), .vga_y (vy0), .vga_colour (vc0), .vga_plot (vp0)
    );

    board_renderer #(.GRID_EN(1'b0)) dut1 (
        .clock_framerate (clk), .resetn (resetn), .start (start),
        .busy (busy1), .done (done1), .row_addr (ra1), .row_data (rd1),
        .blk1_x (bx[0]), .blk1_y (by[0]), .blk2_x (bx[1]), .blk2_y (by[1]),
        .blk3_x (bx[2]), .blk3_y (by[2]), .blk4_x (bx[3]), .blk4_y (by[3]),
        .vga_x (vx1), .vga_y (vy1), .vga_colour (vc1), .vga_plot (vp1)
    );

    // board_state store: registered read port, one cycle behind row_addr
    always @(posedge clk) begin
        rd0 <= (ra0 < 5'd20) ? board[ra0] : 10'd0;
        rd1 <= (ra1 < 5'd20) ? board[ra1] : 10'd0;
    end

    function automatic int model_pix(bit g, int r, int col, int py, int px);
        int x, y, c;
        bit act;
        x = 55 + col * 5 + px;
        y = (10 + (19 - r) * 5 + py) % 128;
        act = 1'b0;
        for (int i = 0; i < 4; i++)
            if (int'(bx[i]) == col && int'(by[i]) == r) act = 1'b1;
        if (g && (px == 4 || py == 4)) c = 1;
        else if (act) c = 4;
        else if (board[r][col]) c = 7;
        else c = 0;
        return (x << 10) | (y << 3) | c;
    endfunction

    task automatic build_expected();
        int idx;
        idx = 0;
        for (int r = 19; r >= 0; r--)
            for (int col = 0; col < 10; col++)
                for (int py = 0; py < 5; py++)
                    for (int px = 0; px < 5; px++) begin
                        exp_pix[0][idx] = model_pix(1'b1, r, col, py, px);
                        exp_pix[1][idx] = model_pix(1'b0, r, col, py, px);
                        idx++;
                    end
    endtask

    task automatic randomize_board();
        for (int r = 0; r < 20; r++) board[r] = 10'($urandom_range(0, 1023));
        for (int i = 0; i < 4; i++) begin
            bx[i] = 4'($urandom_range(0, 11));
            by[i] = 5'($urandom_range(0, 21));
        end
    endtask

    task automatic run_frame(input int restart_at, input int reset_at, input bit wiggle);
        int last_k;
        last_k = (reset_at > 0) ? reset_at + 30 : 5100;
        build_expected();
        for (int d = 0; d < 2; d++) begin
            r_nplot[d] = 0; r_bad[d] = 0; r_ndone[d] = 0; r_done_cyc[d] = -1;
            r_cnt_fill[d] = 0; r_cnt_act[d] = 0;
        end
        r_first_cyc = -1; r_first = -1; r_last = -1; r_busy_bad = 0; r_rst_obs = '1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic p, dn, b, exp_b;
                int got;
                p   = (d == 0) ? vp0 : vp1;
                dn  = (d == 0) ? done0 : done1;
                b   = (d == 0) ? busy0 : busy1;
                got = (d == 0) ? int'({vx0, vy0, vc0}) : int'({vx1, vy1, vc1});
                if (p === 1'b1) begin
                    if (d == 0 && r_first_cyc < 0) begin
                        r_first_cyc = k;
                        r_first = got;
                    end
                    if (d == 0) r_last = got;
                    if (r_nplot[d] < 5000 && got !== exp_pix[d][r_nplot[d]]) begin
                        if (r_bad[d] == 0) begin
                            r_bad_idx[d] = r_nplot[d];
                            r_bad_got[d] = got;
                            r_bad_exp[d] = exp_pix[d][r_nplot[d]];
                        end
                        r_bad[d]++;
                    end
                    r_nplot[d]++;
                    if (got[2:0] == 7) r_cnt_fill[d]++;
                    if (got[2:0] == 4) r_cnt_act[d]++;
                end
                if (dn === 1'b1) begin
                    r_ndone[d]++;
                    if (r_done_cyc[d] < 0) r_done_cyc[d] = k;
                end
                exp_b = (k <= 5040);
                if ((reset_at == 0 || k <= reset_at) && b !== exp_b) r_busy_bad++;
            end
            if (k == 1) start = 1'b0;
            if (k == restart_at) start = 1'b1;
            if (k == restart_at + 1) start = 1'b0;
            if (wiggle) bx[0] = 4'($urandom_range(0, 15));
            if (reset_at > 0 && k == reset_at) resetn = 1'b0;
            if (reset_at > 0 && k == reset_at + 1) begin
                r_rst_obs = {busy0, busy1, vp0, vp1, done0, done1};
                resetn = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({busy0, done0, vp0, busy1, done1, vp1} !== 6'b0) begin
            fails++; $display("FAIL reset_flags got=%b want=000000", {busy0, done0, vp0, busy1, done1, vp1});
        end
        tests++; if ({vx0, vy0, vc0} !== 18'd0) begin
            fails++; $display("FAIL reset_pixel got x=%0d y=%0d c=%0d want 0/0/0", vx0, vy0, vc0);
        end
        tests++; if (ra0 !== 5'd19 || ra1 !== 5'd19) begin
            fails++; $display("FAIL reset_row_addr got=%0d/%0d want=19", ra0, ra1);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy0 !== 1'b0 || vp0 !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset busy=%b plot=%b want 0/0", busy0, vp0);
        end
    endtask

    task automatic test_empty_board();
        for (int r = 0; r < 20; r++) board[r] = 10'd0;
        for (int i = 0; i < 4; i++) begin
            bx[i] = 4'($urandom_range(0, 9));
            by[i] = 5'd22;
        end
        run_frame(0, 0, 1'b0);
        tests++; if (r_nplot[0] != 5000 || r_nplot[1] != 5000) begin
            fails++; $display("FAIL empty_plot_count got=%0d/%0d want=5000", r_nplot[0], r_nplot[1]);
        end
        tests++; if (r_bad[0] != 0) begin
            fails++; $display("FAIL empty_pixels idx=%0d got=%h want=%h", r_bad_idx[0], r_bad_got[0], r_bad_exp[0]);
        end
        tests++; if (r_cnt_fill[0] + r_cnt_act[0] + r_cnt_fill[1] + r_cnt_act[1] != 0) begin
            fails++; $display("FAIL empty_colours non-empty pixels got=%0d want=0",
                              r_cnt_fill[0] + r_cnt_act[0] + r_cnt_fill[1] + r_cnt_act[1]);
        end
        tests++; if (r_first_cyc != 3) begin
            fails++; $display("FAIL first_plot_latency got=%0d want=3", r_first_cyc);
        end
        tests++; if ((r_first >> 3) != ((55 << 7) | 10)) begin
            fails++; $display("FAIL first_plot_xy got=(%0d,%0d) want=(55,10)", r_first >> 10, (r_first >> 3) & 127);
        end
        tests++; if ((r_last >> 3) != ((104 << 7) | 109)) begin
            fails++; $display("FAIL last_plot_xy got=(%0d,%0d) want=(104,109)", r_last >> 10, (r_last >> 3) & 127);
        end
        tests++; if (r_done_cyc[0] != 5041 || r_ndone[0] != 1) begin
            fails++; $display("FAIL empty_done cycle=%0d count=%0d want 5041/1", r_done_cyc[0], r_ndone[0]);
        end
        tests++; if (r_busy_bad != 0) begin
            fails++; $display("FAIL empty_busy wrong cycles got=%0d want=0", r_busy_bad);
        end
    endtask

    task automatic test_filled_bottom();
        for (int r = 0; r < 20; r++) board[r] = 10'd0;
        board[0] = 10'd1;
        for (int i = 0; i < 4; i++) begin
            bx[i] = 4'd3;
            by[i] = 5'd20 + 5'(i);
        end
        run_frame(0, 0, 1'b0);
        tests++; if (r_bad[1] != 0) begin
            fails++; $display("FAIL filled_pixels_nogrid idx=%0d got=%h want=%h", r_bad_idx[1], r_bad_got[1], r_bad_exp[1]);
        end
        tests++; if (r_cnt_fill[1] != 25) begin
            fails++; $display("FAIL filled_count_nogrid got=%0d want=25", r_cnt_fill[1]);
        end
        tests++; if (r_bad[0] != 0 || r_cnt_fill[0] != 16) begin
            fails++; $display("FAIL filled_grid bad=%0d filled=%0d want 0/16", r_bad[0], r_cnt_fill[0]);
        end
    endtask

    task automatic test_active_over_filled();
        for (int r = 0; r < 20; r++) board[r] = 10'd0;
        board[19] = 10'h3ff;
        for (int i = 0; i < 4; i++) begin
            bx[i] = 4'd4;
            by[i] = 5'd19;
        end
        run_frame(0, 0, 1'b0);
        tests++; if (r_bad[1] != 0 || r_bad[0] != 0) begin
            fails++; $display("FAIL active_pixels idx=%0d got=%h want=%h (grid bad=%0d)",
                              r_bad_idx[1], r_bad_got[1], r_bad_exp[1], r_bad[0]);
        end
        tests++; if (r_cnt_act[1] != 25 || r_cnt_fill[1] != 225) begin
            fails++; $display("FAIL active_counts active=%0d filled=%0d want 25/225", r_cnt_act[1], r_cnt_fill[1]);
        end
    endtask

    task automatic test_snapshot();
        randomize_board();
        bx[0] = 4'd2;
        by[0] = 5'd17;
        run_frame(0, 0, 1'b1);
        tests++; if (r_bad[0] != 0 || r_bad[1] != 0) begin
            fails++; $display("FAIL snapshot_pixels bad=%0d/%0d first idx=%0d got=%h want=%h",
                              r_bad[0], r_bad[1], r_bad_idx[0], r_bad_got[0], r_bad_exp[0]);
        end
    endtask

    task automatic test_restart_ignored();
        randomize_board();
        run_frame(100, 0, 1'b0);
        tests++; if (r_ndone[0] != 1 || r_ndone[1] != 1 || r_done_cyc[0] != 5041) begin
            fails++; $display("FAIL restart_done count=%0d/%0d cycle=%0d want 1/1/5041",
                              r_ndone[0], r_ndone[1], r_done_cyc[0]);
        end
        tests++; if (r_nplot[0] != 5000 || r_bad[0] != 0 || r_busy_bad != 0) begin
            fails++; $display("FAIL restart_frame plots=%0d bad=%0d busy_bad=%0d want 5000/0/0",
                              r_nplot[0], r_bad[0], r_busy_bad);
        end
    endtask

    task automatic test_reset_midframe();
        randomize_board();
        run_frame(0, 2000, 1'b0);
        tests++; if (r_rst_obs !== 6'b0) begin
            fails++; $display("FAIL midreset_flags got busy/plot/done=%b want=000000", r_rst_obs);
        end
        tests++; if (r_ndone[0] != 0 || r_ndone[1] != 0) begin
            fails++; $display("FAIL midreset_no_done got=%0d/%0d want=0", r_ndone[0], r_ndone[1]);
        end
        randomize_board();
        run_frame(0, 0, 1'b0);
        tests++; if (r_bad[0] != 0 || r_bad[1] != 0 || r_nplot[0] != 5000 || r_done_cyc[1] != 5041) begin
            fails++; $display("FAIL after_reset_frame bad=%0d/%0d plots=%0d done=%0d want 0/0/5000/5041",
                              r_bad[0], r_bad[1], r_nplot[0], r_done_cyc[1]);
        end
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 3; t++) begin
            randomize_board();
            run_frame(0, 0, 1'b0);
            tests++; if (r_bad[0] != 0 || r_bad[1] != 0) begin
                fails++; $display("FAIL random_pixels[%0d] bad=%0d/%0d idx=%0d got=%h want=%h",
                                  t, r_bad[0], r_bad[1], r_bad_idx[0], r_bad_got[0], r_bad_exp[0]);
            end
            tests++; if (r_nplot[1] != 5000 || r_ndone[1] != 1 || r_done_cyc[1] != 5041) begin
                fails++; $display("FAIL random_frame[%0d] plots=%0d done=%0d at %0d want 5000/1/5041",
                                  t, r_nplot[1], r_ndone[1], r_done_cyc[1]);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        for (int r = 0; r < 20; r++) board[r] = 10'd0;
        for (int i = 0; i < 4; i++) begin
            bx[i] = 4'd0;
            by[i] = 5'd22;
        end
        test_reset();
        test_empty_board();
        test_filled_bottom();
        test_active_over_filled();
        test_snapshot();
        test_restart_ignored();
        test_reset_midframe();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
